// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
// Holds the pointer width function and idle data mode constants.
package rr_arb_mux_pkg;

  localparam int unsigned HOLD_ZERO = 0;
  localparam int unsigned HOLD_KEEP = 1;

  // Pointer needs at least one bit even for tiny N.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping to channel 0; returns one-hot grant and binary index.
module rr_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned N  = 6,
  parameter int unsigned PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [N-1:0]  gnt_hi;
  logic [N-1:0]  gnt_lo;
  logic [PW-1:0] idx_hi;
  logic [PW-1:0] idx_lo;
  logic          hit_hi;
  logic          hit_lo;

  // Two ascending scans: the upper window wins over the wrapped one.
  always_comb begin
    gnt_hi = '0;
    gnt_lo = '0;
    idx_hi = '0;
    idx_lo = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (req[i] && !hit_hi && (i >= int'(ptr))) begin
        hit_hi    = 1'b1;
        gnt_hi[i] = 1'b1;
        idx_hi    = PW'(i);
      end
      if (req[i] && !hit_lo) begin
        hit_lo    = 1'b1;
        gnt_lo[i] = 1'b1;
        idx_lo    = PW'(i);
      end
    end
  end

  assign gnt = hit_hi ? gnt_hi : gnt_lo;
  assign idx = hit_hi ? idx_hi : idx_lo;

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a single registered output slot.
// Reloads in the same cycle it drains, so throughput is one word/cycle.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned K         = 4,
  parameter int unsigned N         = 6,
  parameter int unsigned HOLD_LAST = HOLD_ZERO
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*K-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [K-1:0]   out_data,
  output logic [N-1:0]   out_sel,
  input  logic           out_ready
);

  localparam int unsigned PW = ptr_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic [N-1:0]  gnt;
  logic [PW-1:0] idx;
  logic [K-1:0]  mux_data;
  logic          load_en;
  logic          xfer;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (load_en && !rst) ? gnt : '0;
  assign xfer     = |in_ready;
  assign nxt_ptr  = (idx == PW'(N-1)) ? '0 : idx + PW'(1);

  // AND-OR select keeps the data path flat.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      mux_data = mux_data | (in_data[i*K +: K] & {K{gnt[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= gnt;
      ptr       <= nxt_ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      if (HOLD_LAST != HOLD_KEEP) begin
        out_data <= '0;
      end
    end
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter K, default 4, data width per channel in bits (K >= 1).
REQ-002 Parameter N, default 6, number of input channels (2 <= N <= 16).
REQ-003 Parameter HOLD_LAST, default 0: 1 = output data holds its last value when idle; 0 = output data reads zero when idle.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  N*K  channel i data at bits [i*K +: K].
REQ-008 in_ready  output  N  one-hot or zero; bit i high = channel i transfer accepted this cycle.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_data  output  K  registered data word.
REQ-011 out_sel  output  N  registered one-hot tag of the source channel for out_data.
REQ-012 out_ready  input  1  downstream consumer accepts the word.

Function
REQ-013 Input transfer on channel i: in_valid[i] & in_ready[i] in the same cycle; output transfer: out_valid & out_ready.
REQ-014 load_en = !out_valid | out_ready; the output register accepts a new word only when load_en is 1.
REQ-015 Grant: when load_en = 1 and in_valid != 0, exactly one channel is granted: the first requesting channel at or above pointer ptr, searching upward with wrap from N-1 to 0.
REQ-016 in_ready = grant one-hot when load_en = 1, else all zero; in_ready is combinational from in_valid, ptr, out_valid and out_ready.
REQ-017 On an input transfer from channel g: out_data <= channel g data, out_sel <= one-hot(g), out_valid <= 1, ptr <= (g+1) mod N; latency is 1 cycle from input transfer to out_valid.
REQ-018 Output transfer with no input transfer in the same cycle: out_valid <= 0; out_data <= 0 if HOLD_LAST = 0, else unchanged; out_sel <= 0.
REQ-019 Simultaneous output and input transfer: the register reloads with the new word with no bubble; full throughput is 1 word per cycle.
REQ-020 out_valid = 1 and out_ready = 0: out_data, out_sel and ptr stay stable and in_ready = 0.
REQ-021 ptr changes only on an input transfer; idle cycles leave ptr unchanged.
REQ-022 A single persistent requester is granted every cycle the output drains; with all N requesting, the grants cycle ptr, ptr+1, ... mod N.
REQ-023 Fairness: a continuously requesting channel is granted within N input transfers.
REQ-024 Inputs may change in_data or drop in_valid without a transfer; the block samples only on a transfer.

Reset
REQ-025 While rst = 1 at a clock edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-026 in_ready = 0 during any cycle in which rst = 1.
REQ-027 Reset mid-transfer discards the held word; no input transfer occurs in a reset cycle.
REQ-028 Channel 0 has top priority in the first grant after reset.

Structure
REQ-029 A shared package holds the width function for ptr (clog2 of N, minimum 1) and the HOLD_LAST mode constants.
REQ-030 One sub-module, rr_pick, is combinational: inputs are the N-bit request vector and ptr; outputs are the N-bit one-hot grant and the binary grant index.
REQ-031 The data select is an AND-OR one-hot mux over in_data, driven by the grant; no priority chain on the data path.
REQ-032 The top level holds all registers; rr_pick and the mux hold no state.

Verification (K=4, N=6 unless stated)
REQ-033 Reset, then in_valid=6'b000000 for 3 cycles -> out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
REQ-034 Data 1..6 on channels 0..5, in_valid=6'b111111, out_ready=1 -> out_data sequence 1,2,3,4,5,6,1; out_sel 000001,000010,...,100000,000001.
REQ-035 in_valid=6'b100100, ptr=0, out_ready=1 -> grants ch2, ch5, ch2, ch5; out_data 3,6,3,6.
REQ-036 Word 4 from ch3 held; out_ready=0 for 4 cycles with in_valid=6'b111111 -> out_data=4 and out_sel=001000 stable; in_ready=0; ptr unchanged; next grant is ch4 when out_ready=1.
REQ-037 rst=1 asserted while out_valid=1 -> next cycle out_valid=0, ptr=0; next grant goes to the lowest requesting channel.
REQ-038 HOLD_LAST=1: transfer 5 from ch4, then idle -> out_valid=0, out_data=5, out_sel=0.
